// File: rtl/heat_grid_scan_ctrl.sv
`timescale 1ns/1ps
// Heat-map display refresh sequencer: walks the grid row-major, reads each cell
// from grid RAM and issues one VGA pixel write per cell over valid/ready.
module heat_grid_scan_ctrl #(
  parameter int COLS     = 41,
  parameter int ROWS     = 41,
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8,
  parameter int COORD_W  = 10,
  parameter int X_OFFSET = 1,
  parameter int Y_OFFSET = 1,
  parameter int RD_LAT   = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0]  rd_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [DATA_W-1:0]  pix_data,
  output logic [15:0]        frame_cnt
);

  localparam int I_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int J_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LAT_W = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [I_W-1:0]   i_r;
  logic [J_W-1:0]   j_r;
  logic [LAT_W-1:0] lat_r;
  logic             lat_done_s;
  logic             last_cell_s;
  logic             hs_s;

  // Decode of read-latency expiry, final cell and pixel handshake
  always_comb begin
    lat_done_s  = (lat_r == LAT_W'(RD_LAT - 1));
    last_cell_s = (i_r == I_W'(COLS - 1)) && (j_r == J_W'(ROWS - 1));
    hs_s        = pix_valid && pix_ready;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_READ;
        else       state_s = ST_IDLE;
      end
      ST_READ: state_s = ST_WAIT;
      ST_WAIT: begin
        if (lat_done_s) state_s = ST_WRITE;
        else            state_s = ST_WAIT;
      end
      ST_WRITE: begin
        if (hs_s) begin
          if (last_cell_s) state_s = ST_DONE;
          else             state_s = ST_READ;
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_s;
  end

  // Outputs are registered from the next state so they align with the state they belong to
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      pix_valid <= 1'b0;
      rd_addr   <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_data  <= '0;
      frame_cnt <= 16'd0;
      i_r       <= '0;
      j_r       <= '0;
      lat_r     <= '0;
    end else begin
      busy      <= (state_s != ST_IDLE);
      rd_en     <= (state_s == ST_READ);
      pix_valid <= (state_s == ST_WRITE);
      done      <= (state_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            i_r     <= '0;
            j_r     <= '0;
            rd_addr <= '0;
          end
        end
        ST_READ: lat_r <= '0;
        ST_WAIT: begin
          lat_r <= lat_r + LAT_W'(1);
          if (lat_done_s) begin
            pix_data <= rd_data;
            pix_x    <= COORD_W'(32'(i_r) + 32'(X_OFFSET));
            pix_y    <= COORD_W'(32'(j_r) + 32'(Y_OFFSET));
          end
        end
        ST_WRITE: begin
          if (hs_s && last_cell_s) begin
            frame_cnt <= frame_cnt + 16'd1;
          end else if (hs_s) begin
            // Row-major address just increments, no j*COLS product needed
            rd_addr <= rd_addr + ADDR_W'(1);
            if (i_r == I_W'(COLS - 1)) begin
              i_r <= '0;
              j_r <= j_r + J_W'(1);
            end else begin
              i_r <= i_r + I_W'(1);
            end
          end
        end
        ST_DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_heat_grid_scan_ctrl.sv
`timescale 1ns/1ps
// Bench for heat_grid_scan_ctrl: a 3x2 instance for protocol scenarios and a
// default 41x41 instance for the full-frame scan, both against a grid-walk model.
module tb_heat_grid_scan_ctrl;
  localparam int SC = 3, SR = 2, DC = 41, DR = 41, LAT = 2;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] d;
    int         cyc;
  } hs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0, exp_s_frames = 0;
  logic reset_n;

  logic s_start, s_busy, s_done, s_rd_en, s_pix_valid, s_pix_ready;
  logic [10:0] s_rd_addr;
  logic [7:0]  s_rd_data, s_pix_data;
  logic [9:0]  s_pix_x, s_pix_y;
  logic [15:0] s_frame_cnt;
  logic d_start, d_busy, d_done, d_rd_en, d_pix_valid, d_pix_ready;
  logic [10:0] d_rd_addr;
  logic [7:0]  d_rd_data, d_pix_data;
  logic [9:0]  d_pix_x, d_pix_y;
  logic [15:0] d_frame_cnt;

  heat_grid_scan_ctrl #(.COLS(SC), .ROWS(SR), .RD_LAT(LAT)) u_small (
    .clk(clk), .reset_n(reset_n), .start(s_start), .busy(s_busy), .done(s_done),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .pix_valid(s_pix_valid),
    .pix_ready(s_pix_ready), .pix_x(s_pix_x), .pix_y(s_pix_y), .pix_data(s_pix_data),
    .frame_cnt(s_frame_cnt));

  heat_grid_scan_ctrl u_dflt (
    .clk(clk), .reset_n(reset_n), .start(d_start), .busy(d_busy), .done(d_done),
    .rd_en(d_rd_en), .rd_addr(d_rd_addr), .rd_data(d_rd_data), .pix_valid(d_pix_valid),
    .pix_ready(d_pix_ready), .pix_x(d_pix_x), .pix_y(d_pix_y), .pix_data(d_pix_data),
    .frame_cnt(d_frame_cnt));

  // Grid RAM models with a two-cycle read pipeline; non-strobed reads return a poison word
  logic [7:0] s_mem [0:SC*SR-1];
  logic [7:0] d_mem [0:DC*DR-1];
  logic [7:0] s_p1, s_p2, d_p1, d_p2;
  always @(posedge clk) begin
    s_p1 <= (s_rd_en && s_rd_addr < 11'(SC*SR)) ? s_mem[s_rd_addr] : 8'hA5;
    s_p2 <= s_p1;
    d_p1 <= (d_rd_en && d_rd_addr < 11'(DC*DR)) ? d_mem[d_rd_addr] : 8'hA5;
    d_p2 <= d_p1;
  end
  assign s_rd_data = s_p2;
  assign d_rd_data = d_p2;

  // Observers: handshakes, strobes, done pulses, stall stability and protocol rules
  hs_t  s_hs[$], d_hs[$];
  int   s_rd_cyc[$], s_done_cyc[$], d_rd_cyc[$], d_rd_adr[$], d_done_cyc[$];
  int   s_hold_bad = 0, s_rule_bad = 0, s_stall_n = 0, d_rule_bad = 0;
  logic s_prev_stall = 1'b0;
  logic [9:0] s_px, s_py;
  logic [7:0] s_pd;
  always @(negedge clk) begin
    if (s_pix_valid && s_pix_ready) s_hs.push_back('{s_pix_x, s_pix_y, s_pix_data, cyc});
    if (s_rd_en) s_rd_cyc.push_back(cyc);
    if (s_done) s_done_cyc.push_back(cyc);
    if (s_pix_valid && !s_pix_ready) s_stall_n++;
    if (s_prev_stall && (!s_pix_valid || s_pix_x !== s_px || s_pix_y !== s_py || s_pix_data !== s_pd))
      s_hold_bad++;
    if ((s_rd_en && (s_pix_valid || !s_busy)) || (s_pix_valid && !s_busy) || (s_done && !s_busy))
      s_rule_bad++;
    s_prev_stall = s_pix_valid && !s_pix_ready;
    s_px = s_pix_x; s_py = s_pix_y; s_pd = s_pix_data;
    if (d_pix_valid && d_pix_ready) d_hs.push_back('{d_pix_x, d_pix_y, d_pix_data, cyc});
    if (d_rd_en) begin d_rd_cyc.push_back(cyc); d_rd_adr.push_back(int'(d_rd_addr)); end
    if (d_done) d_done_cyc.push_back(cyc);
    if ((d_rd_en && (d_pix_valid || !d_busy)) || (d_pix_valid && !d_busy) || (d_done && !d_busy))
      d_rule_bad++;
  end

  // Reference: one frame is every cell row-major, x=i+1, y=j+1, data = RAM word at j*cols+i
  hs_t exp_q[$];
  function automatic void model_frame(input bit big);
    int cols = big ? DC : SC;
    int rows = big ? DR : SR;
    for (int j = 0; j < rows; j++)
      for (int i = 0; i < cols; i++)
        exp_q.push_back('{10'(i + 1), 10'(j + 1), big ? d_mem[j*cols+i] : s_mem[j*cols+i], 0});
  endfunction

  task automatic wait_done(input bit big, input int budget);
    int c;
    for (c = 0; c < budget; c++) begin
      @(negedge clk);
      if (big ? d_done : s_done) break;
    end
    total++;
    if (c == budget) begin
      bad++;
      $display("FAIL wait_done big=%0d: done seen=0 required=1 within %0d cycles", big, budget);
    end
  endtask

  task automatic pulse_start(input bit big);
    @(posedge clk); #1;
    if (big) d_start = 1'b1; else s_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0; s_start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; s_start = 1'b1; d_start = 1'b1; s_pix_ready = 1'b1; d_pix_ready = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if ({s_busy, s_done, s_rd_en, s_pix_valid, s_pix_x, s_pix_y, s_pix_data, s_frame_cnt, s_rd_addr} !== '0) begin
      bad++; $display("FAIL reset_small: busy=%b done=%b rd_en=%b valid=%b x=%0d y=%0d data=%0d fc=%0d addr=%0d required all 0",
        s_busy, s_done, s_rd_en, s_pix_valid, s_pix_x, s_pix_y, s_pix_data, s_frame_cnt, s_rd_addr);
    end
    total++;
    if ({d_busy, d_done, d_rd_en, d_pix_valid, d_pix_x, d_pix_y, d_pix_data, d_frame_cnt, d_rd_addr} !== '0) begin
      bad++; $display("FAIL reset_dflt: outputs not all 0 (busy=%b rd_en=%b fc=%0d)", d_busy, d_rd_en, d_frame_cnt);
    end
    total++;
    if (s_rd_cyc.size() + d_rd_cyc.size() != 0) begin
      bad++; $display("FAIL reset_rd_en: strobes=%0d required 0", s_rd_cyc.size() + d_rd_cyc.size());
    end
    d_start = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if ({s_busy, s_rd_en, s_rd_addr, d_busy} !== {1'b1, 1'b1, 11'd0, 1'b0}) begin
      bad++; $display("FAIL reset_release: busy=%b rd_en=%b addr=%0d dbusy=%b required 1 1 0 0",
        s_busy, s_rd_en, s_rd_addr, d_busy);
    end
    s_start = 1'b0;
    wait_done(1'b0, 200);
    exp_s_frames++;
    @(negedge clk);
    total++;
    if (s_frame_cnt !== 16'(exp_s_frames) || s_busy !== 1'b0) begin
      bad++; $display("FAIL reset_first_frame: fc=%0d busy=%b required %0d 0", s_frame_cnt, s_busy, exp_s_frames);
    end
  endtask

  task automatic test_small_scan();
    int b = s_hs.size(), nb = s_done_cyc.size();
    for (int a = 0; a < SC*SR; a++) s_mem[a] = 8'(a + 16);
    exp_q.delete(); model_frame(1'b0);
    s_pix_ready = 1'b1;
    pulse_start(1'b0);
    wait_done(1'b0, 200);
    total++;
    if (s_busy !== 1'b1) begin bad++; $display("FAIL small_busy_in_done: busy=%b required 1", s_busy); end
    @(negedge clk);
    exp_s_frames++;
    total++;
    if ({s_busy, s_done, s_frame_cnt} !== {1'b0, 1'b0, 16'(exp_s_frames)}) begin
      bad++; $display("FAIL small_after_done: busy=%b done=%b fc=%0d required 0 0 %0d", s_busy, s_done, s_frame_cnt, exp_s_frames);
    end
    total++;
    if (s_hs.size() - b != 6 || s_done_cyc.size() - nb != 1) begin
      bad++; $display("FAIL small_counts: writes=%0d dones=%0d required 6 1", s_hs.size() - b, s_done_cyc.size() - nb);
    end
    for (int k = 0; k < 6 && b + k < s_hs.size(); k++) begin
      total++;
      if (s_hs[b+k].x !== exp_q[k].x || s_hs[b+k].y !== exp_q[k].y || s_hs[b+k].d !== exp_q[k].d) begin
        bad++; $display("FAIL small_write%0d: got (%0d,%0d,%0d) required (%0d,%0d,%0d)", k,
          s_hs[b+k].x, s_hs[b+k].y, s_hs[b+k].d, exp_q[k].x, exp_q[k].y, exp_q[k].d);
      end
      if (k > 0) begin
        total++;
        if (s_hs[b+k].cyc - s_hs[b+k-1].cyc != LAT + 2) begin
          bad++; $display("FAIL small_spacing%0d: got %0d required %0d", k, s_hs[b+k].cyc - s_hs[b+k-1].cyc, LAT + 2);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int b = s_hs.size(), st0 = s_stall_n, h0 = s_hold_bad, r0 = s_rule_bad, stalls = 0, c;
    for (int a = 0; a < SC*SR; a++) s_mem[a] = 8'($urandom_range(0, 255));
    exp_q.delete(); model_frame(1'b0);
    s_pix_ready = 1'b1;
    pulse_start(1'b0);
    for (c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (s_done) break;
      if (s_pix_valid && s_pix_x == 10'd2 && s_pix_y == 10'd1 && stalls < 5) begin
        s_pix_ready = 1'b0;
        stalls++;
        total++;
        if (s_pix_data !== s_mem[1] || s_rd_en !== 1'b0) begin
          bad++; $display("FAIL bp_stall%0d: data=%0d rd_en=%b required %0d 0", stalls, s_pix_data, s_rd_en, s_mem[1]);
        end
      end else begin
        s_pix_ready = 1'b1;
      end
    end
    exp_s_frames++;
    repeat (2) @(negedge clk);
    total++;
    if (s_stall_n - st0 != 5 || s_hold_bad != h0 || s_rule_bad != r0) begin
      bad++; $display("FAIL bp_stall_rules: stalls=%0d holdbad=%0d rulebad=%0d required 5 0 0",
        s_stall_n - st0, s_hold_bad - h0, s_rule_bad - r0);
    end
    total++;
    if (s_hs.size() - b != 6 || s_frame_cnt !== 16'(exp_s_frames)) begin
      bad++; $display("FAIL bp_counts: writes=%0d fc=%0d required 6 %0d", s_hs.size() - b, s_frame_cnt, exp_s_frames);
    end
    for (int k = 0; k < 6 && b + k < s_hs.size(); k++) begin
      total++;
      if (s_hs[b+k].x !== exp_q[k].x || s_hs[b+k].y !== exp_q[k].y || s_hs[b+k].d !== exp_q[k].d) begin
        bad++; $display("FAIL bp_write%0d: got (%0d,%0d,%0d) required (%0d,%0d,%0d)", k,
          s_hs[b+k].x, s_hs[b+k].y, s_hs[b+k].d, exp_q[k].x, exp_q[k].y, exp_q[k].d);
      end
    end
  endtask

  task automatic test_busy_start();
    int b = s_hs.size(), nb = s_done_cyc.size(), h0 = s_hold_bad, rb, c;
    for (int a = 0; a < SC*SR; a++) s_mem[a] = 8'($urandom_range(0, 255));
    exp_q.delete(); model_frame(1'b0);
    pulse_start(1'b0);
    for (c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      s_pix_ready = ($urandom_range(0, 3) != 0);
      s_start = (c == 5 || c == 9 || c == 14);
      if (s_done) break;
    end
    s_start = 1'b0; s_pix_ready = 1'b1;
    exp_s_frames++;
    @(negedge clk);
    rb = s_rd_cyc.size();
    repeat (10) @(negedge clk);
    total++;
    if (s_done_cyc.size() - nb != 1 || s_rd_cyc.size() != rb || s_busy !== 1'b0 || s_hold_bad != h0) begin
      bad++; $display("FAIL busy_start: dones=%0d late_rd=%0d busy=%b holdbad=%0d required 1 0 0 0",
        s_done_cyc.size() - nb, s_rd_cyc.size() - rb, s_busy, s_hold_bad - h0);
    end
    total++;
    if (s_hs.size() - b != 6) begin bad++; $display("FAIL busy_writes: got %0d required 6", s_hs.size() - b); end
    for (int k = 0; k < 6 && b + k < s_hs.size(); k++) begin
      total++;
      if (s_hs[b+k].x !== exp_q[k].x || s_hs[b+k].y !== exp_q[k].y || s_hs[b+k].d !== exp_q[k].d) begin
        bad++; $display("FAIL busy_write%0d: got (%0d,%0d,%0d) required (%0d,%0d,%0d)", k,
          s_hs[b+k].x, s_hs[b+k].y, s_hs[b+k].d, exp_q[k].x, exp_q[k].y, exp_q[k].d);
      end
    end
  endtask

  task automatic test_back_to_back();
    int b = s_hs.size(), nb = s_done_cyc.size(), nd = 0, gap = -1, c;
    for (int a = 0; a < SC*SR; a++) s_mem[a] = 8'($urandom_range(0, 255));
    exp_q.delete(); model_frame(1'b0); model_frame(1'b0);
    s_pix_ready = 1'b1;
    @(posedge clk); #1; s_start = 1'b1;
    for (c = 0; c < 400 && nd < 2; c++) begin
      @(posedge clk); #1;
      if (s_done) begin
        nd++;
        if (nd == 2) s_start = 1'b0;
        else begin
          @(posedge clk); #1;
          total++;
          if (s_busy !== 1'b0 || s_frame_cnt !== 16'(exp_s_frames + 1)) begin
            bad++; $display("FAIL b2b_idle: busy=%b fc=%0d required 0 %0d", s_busy, s_frame_cnt, exp_s_frames + 1);
          end
        end
      end
    end
    s_start = 1'b0;
    exp_s_frames += 2;
    repeat (4) @(negedge clk);
    total++;
    if (nd != 2 || s_busy !== 1'b0 || s_frame_cnt !== 16'(exp_s_frames) || s_hs.size() - b != 12) begin
      bad++; $display("FAIL b2b_counts: dones=%0d busy=%b fc=%0d writes=%0d required 2 0 %0d 12",
        nd, s_busy, s_frame_cnt, s_hs.size() - b, exp_s_frames);
    end
    if (s_done_cyc.size() > nb) begin
      foreach (s_rd_cyc[k]) if (gap < 0 && s_rd_cyc[k] > s_done_cyc[nb]) gap = s_rd_cyc[k] - s_done_cyc[nb];
    end
    total++;
    if (gap != 2) begin bad++; $display("FAIL b2b_gap: done-to-read got %0d required 2", gap); end
    for (int k = 0; k < 12 && b + k < s_hs.size(); k++) begin
      total++;
      if (s_hs[b+k].x !== exp_q[k].x || s_hs[b+k].y !== exp_q[k].y || s_hs[b+k].d !== exp_q[k].d) begin
        bad++; $display("FAIL b2b_write%0d: got (%0d,%0d,%0d) required (%0d,%0d,%0d)", k,
          s_hs[b+k].x, s_hs[b+k].y, s_hs[b+k].d, exp_q[k].x, exp_q[k].y, exp_q[k].d);
      end
    end
  endtask

  task automatic test_full_scan();
    int b = d_hs.size(), rb = d_rd_cyc.size(), nb = d_done_cyc.size(), nerr = 0;
    for (int a = 0; a < DC*DR; a++) d_mem[a] = 8'($urandom_range(0, 255));
    exp_q.delete(); model_frame(1'b1);
    d_pix_ready = 1'b1;
    pulse_start(1'b1);
    wait_done(1'b1, 8000);
    repeat (2) @(negedge clk);
    total++;
    if (d_hs.size() - b != DC*DR || d_rd_cyc.size() - rb != DC*DR || d_frame_cnt !== 16'd1 || d_rule_bad != 0) begin
      bad++; $display("FAIL full_counts: writes=%0d reads=%0d fc=%0d rulebad=%0d required %0d %0d 1 0",
        d_hs.size() - b, d_rd_cyc.size() - rb, d_frame_cnt, d_rule_bad, DC*DR, DC*DR);
    end
    for (int k = 0; k < DC*DR && b + k < d_hs.size(); k++) begin
      total++;
      if (d_hs[b+k].x !== exp_q[k].x || d_hs[b+k].y !== exp_q[k].y || d_hs[b+k].d !== exp_q[k].d) begin
        bad++; nerr++;
        if (nerr < 8) $display("FAIL full_write%0d: got (%0d,%0d,%0d) required (%0d,%0d,%0d)", k,
          d_hs[b+k].x, d_hs[b+k].y, d_hs[b+k].d, exp_q[k].x, exp_q[k].y, exp_q[k].d);
      end
    end
    total++;
    if (d_hs.size() == 0 || d_hs[$].x !== 10'd41 || d_hs[$].y !== 10'd41 || d_rd_adr.size() == 0 || d_rd_adr[$] != 1680) begin
      bad++; $display("FAIL full_last_cell: last write or last address wrong, required (41,41) at addr 1680");
    end
    total++;
    if (d_done_cyc.size() - nb != 1 || d_rd_cyc.size() <= rb || d_done_cyc[$] - d_rd_cyc[rb] != 6724) begin
      bad++; $display("FAIL full_duration: dones=%0d first-read-to-done required 6724", d_done_cyc.size() - nb);
    end
  endtask

  task automatic test_reset_mid();
    int nb, rb, c;
    d_pix_ready = 1'b1;
    pulse_start(1'b1);
    for (c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (d_rd_en && d_rd_addr == 11'd7) break;
    end
    @(posedge clk); #2;
    nb = d_done_cyc.size();
    total++;
    if (c == 200 || d_busy !== 1'b1 || d_frame_cnt !== 16'd1) begin
      bad++; $display("FAIL mid_pre: reached=%0d busy=%b fc=%0d required 1 1 1", c < 200, d_busy, d_frame_cnt);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({d_busy, d_done, d_rd_en, d_pix_valid, d_pix_x, d_pix_y, d_pix_data, d_frame_cnt, d_rd_addr} !== '0) begin
      bad++; $display("FAIL mid_async_clear: busy=%b rd_en=%b x=%0d data=%0d fc=%0d addr=%0d required all 0",
        d_busy, d_rd_en, d_pix_x, d_pix_data, d_frame_cnt, d_rd_addr);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_s_frames = 0;
    rb = d_rd_cyc.size();
    repeat (20) @(negedge clk);
    total++;
    if (d_busy !== 1'b0 || d_done_cyc.size() != nb || d_rd_cyc.size() != rb || d_frame_cnt !== 16'd0) begin
      bad++; $display("FAIL mid_no_resume: busy=%b dones=%0d reads=%0d fc=%0d required 0 0 0 0",
        d_busy, d_done_cyc.size() - nb, d_rd_cyc.size() - rb, d_frame_cnt);
    end
    total++;
    if (s_frame_cnt !== 16'(exp_s_frames) || s_busy !== 1'b0) begin
      bad++; $display("FAIL mid_small_cleared: fc=%0d busy=%b required 0 0", s_frame_cnt, s_busy);
    end
  endtask

  initial begin
    test_reset();
    test_small_scan();
    test_backpressure();
    test_busy_start();
    test_back_to_back();
    test_full_scan();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/heat_grid_scan_ctrl.md
Name: heat_grid_scan_ctrl

Overview:
- Sequences one full refresh of the heat-map grid: walks every cell (column i, row j) in row-major order and reads its temperature word from grid memory.
- Maps (i, j) to VGA pixel coordinates (i+X_OFFSET, j+Y_OFFSET) and issues one pixel write per cell to the VGA pixel writer over a valid/ready handshake.
- Sits between the simulation grid RAM and the VGA write port, and owns the only read port the display path uses.

Parameters:
- COLS, 41, grid columns (i = 0..COLS-1)
- ROWS, 41, grid rows (j = 0..ROWS-1)
- ADDR_W, 11, grid RAM address width; must satisfy COLS*ROWS <= 2^ADDR_W
- DATA_W, 8, temperature/colour word width
- COORD_W, 10, pixel coordinate width
- X_OFFSET, 1, added to i to form pix_x
- Y_OFFSET, 1, added to j to form pix_y
- RD_LAT, 2, grid RAM read latency in cycles (>= 1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  level-sampled; begins a scan when idle
- busy  out  1  high from scan start through final handshake
- done  out  1  one-cycle pulse after the last cell is written
- rd_en  out  1  one-cycle grid RAM read strobe
- rd_addr  out  ADDR_W  grid RAM address, j*COLS+i
- rd_data  in  DATA_W  read data, valid RD_LAT cycles after rd_en
- pix_valid  out  1  pixel write request
- pix_ready  in  1  pixel writer accepts when high with pix_valid
- pix_x  out  COORD_W  i+X_OFFSET
- pix_y  out  COORD_W  j+Y_OFFSET
- pix_data  out  DATA_W  captured rd_data for this cell
- frame_cnt  out  16  count of completed scans, wraps 65535->0

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE; i, j, rd_addr, lat counter = 0; busy, done, rd_en, pix_valid = 0; pix_x, pix_y, pix_data = 0; frame_cnt = 0. Reset asserted mid-scan aborts the scan immediately with no done pulse; the scan does not resume after release.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE: if start=1, clear i, j, rd_addr and go to READ; busy rises in the same edge.
- READ (1 cycle): rd_en=1, rd_addr holds the current cell address. Next state WAIT.
- WAIT (RD_LAT cycles): lat counter runs; on the edge ending cycle t+RD_LAT (t = READ cycle), capture rd_data into pix_data, load pix_x/pix_y, and go to WRITE.
- WRITE: pix_valid=1. pix_x, pix_y, pix_data are held stable while pix_ready=0; there is no timeout. On the edge with pix_valid&&pix_ready: if i=COLS-1 and j=ROWS-1, go to DONE. Otherwise advance: i+1, or i=0 and j+1 at end of row. rd_addr increments by 1 (no multiplier), then go to READ.
- DONE (1 cycle): done=1, frame_cnt+1, busy stays 1 in this cycle; next state IDLE with busy=0.
- Per-cell cost with pix_ready tied high: RD_LAT+2 cycles. Default full scan = 1681*4 = 6724 cycles from the first READ to the final handshake.
- start while busy: ignored. start held high continuously: a new scan begins on the IDLE cycle after DONE (back-to-back frames).
- Arithmetic: pix_x and pix_y are zero-extended sums truncated to COORD_W. rd_addr is never out of range (0..COLS*ROWS-1).
- rd_en is never high outside READ; pix_valid is never high outside WRITE.

Test Plan:
- Reset values: hold reset_n=0 with start=1 -> all outputs 0, state IDLE, no rd_en. Release -> scan begins on the first edge with start=1.
- Small scan: COLS=3, ROWS=2, RD_LAT=2, pix_ready=1, one start pulse, RAM model returns data=addr+16 -> six writes (x,y,data) = (1,1,16), (2,1,17), (3,1,18), (1,2,19), (2,2,20), (3,2,21). Writes spaced 4 cycles apart. done pulses once. frame_cnt=1.
- Backpressure: pix_ready low for 5 cycles on cell (1,0) -> pix_x=2, pix_y=1, pix_data held constant; no rd_en during the stall; exactly one write accepted per cell.
- Default full scan: COLS=ROWS=41, ready=1 -> 1681 handshakes. Last write is (41,41) at rd_addr 1680. done is asserted 6724 cycles after the first rd_en.
- Start during busy / held start: start pulsed mid-scan -> no restart. start held high -> two consecutive frames, frame_cnt 1 then 2, one IDLE cycle between them.
- Reset mid-scan: assert reset_n=0 during WAIT of cell 7 -> outputs cleared asynchronously, no done pulse, frame_cnt=0.
